polyphony_allocator: RTL and testbench

Parametrised voice allocator that maps a stream of note-on/note-off events onto `NUM_VOICES` oscillator voice slots, with retrigger, age tracking and oldest-voice stealing. It is the successor to the fixed 4-voice polyphony controller. It sits between the MIDI decoder and the per-voice synthesis datapath. Each voice slot holds a note number and velocity, and reports them with a per-voice enable.

---
 rtl/conFFTi.sv | 25 ++
 rtl/voice_age_tracker.sv | 69 ++++++
 rtl/polyphony_allocator.sv | 141 ++++++++++++++
 tb/tb_polyphony_allocator.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conFFTi.sv
// conFFTi: shared types for the polyphony voice allocator and its datapath consumers.
package conFFTi;

  localparam int DEFAULT_NOTE_W = 7;
  localparam int DEFAULT_VEL_W  = 7;

  typedef enum logic {
    NOTE_OFF = 1'b0,
    NOTE_ON  = 1'b1
  } note_en_t;

  typedef struct packed {
    logic                      active;
    logic [DEFAULT_NOTE_W-1:0] note;
    logic [DEFAULT_VEL_W-1:0]  vel;
  } voice_t;

  // Age-tracker operations: touch makes the selected voice newest, release removes it from the ranking
  typedef enum logic [1:0] {
    AGE_HOLD    = 2'd0,
    AGE_TOUCH   = 2'd1,
    AGE_RELEASE = 2'd2
  } age_op_t;

endpackage

// File: rtl/voice_age_tracker.sv
// voice_age_tracker: keeps a newest-first rank (0 = newest) for every active voice.
// Build option POLYPHONY_VOICE_STEAL_EN adds the one-hot oldest-voice output.
module voice_age_tracker
  import conFFTi::*;
#(
  parameter int NUM_VOICES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_VOICES-1:0] active,
  input  age_op_t               op,
  input  logic [NUM_VOICES-1:0] sel
`ifdef POLYPHONY_VOICE_STEAL_EN
  ,
  output logic [NUM_VOICES-1:0] oldest
`endif
);

  localparam int AGE_W = $clog2(NUM_VOICES);

  logic [NUM_VOICES-1:0][AGE_W-1:0] age_q;
  logic [AGE_W-1:0]                 sel_age;
  logic                             sel_active;

  // Current rank of the selected voice, and whether it was already ranked
  always_comb begin
    sel_age    = '0;
    sel_active = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (sel[i]) begin
        sel_age    = sel_age | age_q[i];
        sel_active = sel_active | active[i];
      end
    end
  end

  // Touch: selected voice becomes 0 and everyone newer than it shifts back one;
  // a freshly allocated voice was unranked, so every active voice shifts back.
  // Release: everyone older than the released voice moves forward one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      age_q <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (op == AGE_TOUCH) begin
          if (sel[i])
            age_q[i] <= '0;
          else if (active[i] && (!sel_active || (age_q[i] < sel_age)))
            age_q[i] <= age_q[i] + 1'b1;
        end else if (op == AGE_RELEASE) begin
          if (sel[i])
            age_q[i] <= '0;
          else if (active[i] && (age_q[i] > sel_age))
            age_q[i] <= age_q[i] - 1'b1;
        end
      end
    end
  end

`ifdef POLYPHONY_VOICE_STEAL_EN
  // Oldest voice is the active one holding the largest possible rank (only meaningful when full)
  always_comb begin
    oldest = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      oldest[i] = active[i] && (age_q[i] == AGE_W'(NUM_VOICES - 1));
  end
`endif

endmodule

// File: rtl/polyphony_allocator.sv
// polyphony_allocator: maps note-on/note-off events onto NUM_VOICES voice slots with
// retrigger and age tracking. Build option POLYPHONY_VOICE_STEAL_EN: when every voice
// is busy, steal the oldest voice instead of dropping the incoming note.
module polyphony_allocator
  import conFFTi::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_W     = DEFAULT_NOTE_W,
  parameter int VEL_W      = DEFAULT_VEL_W
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 input_en,
  input  note_en_t                             note_in_en,
  input  logic [NOTE_W-1:0]                    note_in,
  input  logic [VEL_W-1:0]                     velocity_in,
  output logic [NUM_VOICES-1:0]                notes_out_en,
  output logic [NUM_VOICES-1:0][NOTE_W-1:0]    notes_out,
  output logic [NUM_VOICES-1:0][VEL_W-1:0]     velocities_out,
  output logic                                 voices_full,
  output logic                                 note_dropped,
  output logic                                 voice_stolen
);

  logic [NUM_VOICES-1:0] match_vec;
  logic [NUM_VOICES-1:0] free_vec;
  logic [NUM_VOICES-1:0] first_free;
  logic [NUM_VOICES-1:0] steal_sel;
  logic [NUM_VOICES-1:0] load_sel;
  logic [NUM_VOICES-1:0] release_sel;
  logic [NUM_VOICES-1:0] active_d;
  logic [NUM_VOICES-1:0] age_sel;
  logic                  any_match;
  logic                  is_on;
  logic                  is_off;
  logic                  do_retrig;
  logic                  do_alloc;
  logic                  do_full;
  logic                  do_release;
  age_op_t               age_op;

  // Find the active voice already playing the incoming note (retrigger keeps it unique)
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      match_vec[i] = notes_out_en[i] && (notes_out[i] == note_in);
  end

  assign any_match  = |match_vec;
  assign free_vec   = ~notes_out_en;
  assign first_free = free_vec & (~free_vec + 1'b1);

  // A note-on with zero velocity is a note-off
  assign is_on      = input_en && (note_in_en == NOTE_ON) && (velocity_in != '0);
  assign is_off     = input_en && !is_on;

  assign do_retrig  = is_on && any_match;
  assign do_alloc   = is_on && !any_match && !voices_full;
  assign do_full    = is_on && !any_match && voices_full;
  assign do_release = is_off && any_match;

`ifdef POLYPHONY_VOICE_STEAL_EN
  logic [NUM_VOICES-1:0] oldest;
  assign steal_sel = do_full ? oldest : '0;
`else
  assign steal_sel = '0;
`endif

  assign load_sel    = do_retrig ? match_vec : (do_alloc ? first_free : steal_sel);
  assign release_sel = do_release ? match_vec : '0;
  assign active_d    = (notes_out_en | load_sel) & ~release_sel;

  // Translate the classified event into an age-tracker operation
  always_comb begin
    age_op  = AGE_HOLD;
    age_sel = '0;
    if (|load_sel) begin
      age_op  = AGE_TOUCH;
      age_sel = load_sel;
    end else if (do_release) begin
      age_op  = AGE_RELEASE;
      age_sel = release_sel;
    end
  end

  voice_age_tracker #(
    .NUM_VOICES(NUM_VOICES)
  ) u_age_tracker (
    .clk    (clk),
    .reset  (reset),
    .active (notes_out_en),
    .op     (age_op),
    .sel    (age_sel)
`ifdef POLYPHONY_VOICE_STEAL_EN
    ,
    .oldest (oldest)
`endif
  );

  // Voice registers; a released voice keeps its note and velocity
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      notes_out_en   <= '0;
      notes_out      <= '0;
      velocities_out <= '0;
      voices_full    <= 1'b0;
    end else begin
      notes_out_en <= active_d;
      voices_full  <= &active_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (load_sel[i]) begin
          notes_out[i]      <= note_in;
          velocities_out[i] <= velocity_in;
        end
      end
    end
  end

`ifdef POLYPHONY_VOICE_STEAL_EN
  assign note_dropped = 1'b0;

  // One-cycle pulse whenever a busy voice is reassigned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      voice_stolen <= 1'b0;
    else
      voice_stolen <= do_full;
  end
`else
  assign voice_stolen = 1'b0;

  // One-cycle pulse whenever a note-on finds no voice
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      note_dropped <= 1'b0;
    else
      note_dropped <= do_full;
  end
`endif

endmodule

// File: tb/tb_polyphony_allocator.sv
// tb_polyphony_allocator: scoreboard bench for a 4-voice polyphony_allocator.
// Reference model keeps voices in a newest-first queue; a voice's age is its queue position.
module tb_polyphony_allocator;
  import conFFTi::*;

  localparam int NV = 4;

  typedef struct packed {
    logic [NV-1:0]      en;
    logic [NV-1:0][6:0] notes;
    logic [NV-1:0][6:0] vels;
    logic [NV-1:0][1:0] ages;
    logic               full;
    logic               dropped;
    logic               stolen;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               input_en = 1'b0;
  note_en_t           note_in_en = NOTE_OFF;
  logic [6:0]         note_in = '0;
  logic [6:0]         velocity_in = '0;
  logic [NV-1:0]      notes_out_en;
  logic [NV-1:0][6:0] notes_out;
  logic [NV-1:0][6:0] velocities_out;
  logic               voices_full;
  logic               note_dropped;
  logic               voice_stolen;

  int     checks = 0;
  int     errors = 0;
  voice_t mv [NV];
  int     order [$];
  exp_t   exp_q [$];

  polyphony_allocator #(
    .NUM_VOICES(NV),
    .NOTE_W    (7),
    .VEL_W     (7)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .input_en      (input_en),
    .note_in_en    (note_in_en),
    .note_in       (note_in),
    .velocity_in   (velocity_in),
    .notes_out_en  (notes_out_en),
    .notes_out     (notes_out),
    .velocities_out(velocities_out),
    .voices_full   (voices_full),
    .note_dropped  (note_dropped),
    .voice_stolen  (voice_stolen)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void order_remove(input int m);
    for (int k = 0; k < order.size(); k++) begin
      if (order[k] == m) begin
        order.delete(k);
        break;
      end
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) mv[i] = '0;
    order.delete();
  endtask

  task automatic model_event(input bit en, input note_en_t kind, input logic [6:0] n,
                             input logic [6:0] v, output exp_t e);
    int m;
    int f;
    bit dropped;
    bit stolen;
    m = -1;
    f = -1;
    dropped = 1'b0;
    stolen = 1'b0;
    if (en) begin
      for (int i = 0; i < NV; i++) if (mv[i].active && mv[i].note == n) m = i;
      if (kind == NOTE_ON && v != 0) begin
        if (m >= 0) begin
          mv[m].vel = v;
          order_remove(m);
          order.push_front(m);
        end else if (order.size() < NV) begin
          for (int i = NV - 1; i >= 0; i--) if (!mv[i].active) f = i;
          mv[f].active = 1'b1;
          mv[f].note = n;
          mv[f].vel = v;
          order.push_front(f);
        end else begin
`ifdef POLYPHONY_VOICE_STEAL_EN
          f = order.pop_back();
          mv[f].note = n;
          mv[f].vel = v;
          order.push_front(f);
          stolen = 1'b1;
`else
          dropped = 1'b1;
`endif
        end
      end else if (m >= 0) begin
        mv[m].active = 1'b0;
        order_remove(m);
      end
    end
    e = '0;
    for (int i = 0; i < NV; i++) begin
      e.en[i] = mv[i].active;
      e.notes[i] = mv[i].note;
      e.vels[i] = mv[i].vel;
    end
    for (int k = 0; k < order.size(); k++) e.ages[order[k]] = 2'(k);
    e.full = (order.size() == NV);
    e.dropped = dropped;
    e.stolen = stolen;
  endtask

  task automatic compare_expected(input exp_t e);
    for (int i = 0; i < NV; i++) begin
      checkOutput($sformatf("v%0d_active", i), 32'(notes_out_en[i]), 32'(e.en[i]));
      checkOutput($sformatf("v%0d_note", i), 32'(notes_out[i]), 32'(e.notes[i]));
      checkOutput($sformatf("v%0d_vel", i), 32'(velocities_out[i]), 32'(e.vels[i]));
      if (e.en[i])
        checkOutput($sformatf("v%0d_age", i), 32'(dut.u_age_tracker.age_q[i]), 32'(e.ages[i]));
    end
    checkOutput("voices_full", 32'(voices_full), 32'(e.full));
    checkOutput("note_dropped", 32'(note_dropped), 32'(e.dropped));
    checkOutput("voice_stolen", 32'(voice_stolen), 32'(e.stolen));
  endtask

  task automatic applyStimulus(input bit en, input note_en_t kind, input int n, input int v);
    exp_t e;
    @(negedge clk);
    input_en = en;
    note_in_en = kind;
    note_in = 7'(n);
    velocity_in = 7'(v);
    model_event(en, kind, 7'(n), 7'(v), e);
    exp_q.push_back(e);
  endtask

  task automatic note_on(input int n, input int v);
    applyStimulus(1'b1, NOTE_ON, n, v);
  endtask

  task automatic note_off(input int n);
    applyStimulus(1'b1, NOTE_OFF, n, 0);
  endtask

  task automatic quiesce();
    @(negedge clk);
    input_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    input_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_active", 32'(notes_out_en), 32'd0);
    checkOutput("rst_notes", 32'(notes_out), 32'd0);
    checkOutput("rst_vels", 32'(velocities_out), 32'd0);
    checkOutput("rst_full", 32'(voices_full), 32'd0);
    checkOutput("rst_dropped", 32'(note_dropped), 32'd0);
    checkOutput("rst_stolen", 32'(voice_stolen), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: one expected record per sampled event, compared just after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) compare_expected(exp_q.pop_front());
    end
  end

  initial begin
    model_reset();
    do_reset();

    // three allocations fill voices 0..2 in order
    note_on(60, 100); note_on(64, 90); note_on(67, 80);
    quiesce();
    checkOutput("t1_active", 32'(notes_out_en), 32'h7);
    checkOutput("t1_note2", 32'(notes_out[2]), 32'd67);
    checkOutput("t1_vel0", 32'(velocities_out[0]), 32'd100);
    checkOutput("t1_age0", 32'(dut.u_age_tracker.age_q[0]), 32'd2);
    checkOutput("t1_age2", 32'(dut.u_age_tracker.age_q[2]), 32'd0);
    checkOutput("t1_full", 32'(voices_full), 32'd0);

    // full: steal oldest or drop
    do_reset();
    note_on(60, 10); note_on(64, 10); note_on(67, 10); note_on(72, 10);
    note_on(76, 50);
    quiesce();
`ifdef POLYPHONY_VOICE_STEAL_EN
    checkOutput("t2_note0", 32'(notes_out[0]), 32'd76);
    checkOutput("t2_vel0", 32'(velocities_out[0]), 32'd50);
    checkOutput("t2_stolen", 32'(voice_stolen), 32'd1);
`else
    checkOutput("t2_note0", 32'(notes_out[0]), 32'd60);
    checkOutput("t2_vel0", 32'(velocities_out[0]), 32'd10);
    checkOutput("t2_dropped", 32'(note_dropped), 32'd1);
`endif

    // retrigger updates velocity and age only
    do_reset();
    note_on(60, 40); note_on(64, 40); note_on(60, 20);
    quiesce();
    checkOutput("t3_vel0", 32'(velocities_out[0]), 32'd20);
    checkOutput("t3_active", 32'(notes_out_en), 32'h3);
    checkOutput("t3_age0", 32'(dut.u_age_tracker.age_q[0]), 32'd0);
    checkOutput("t3_age1", 32'(dut.u_age_tracker.age_q[1]), 32'd1);
    note_on(62, 5);
    quiesce();
    checkOutput("t3_note2", 32'(notes_out[2]), 32'd62);

    // release compacts ages, freed slot is reused
    do_reset();
    note_on(60, 30); note_on(64, 30); note_on(67, 30); note_off(64);
    quiesce();
    checkOutput("t4_active", 32'(notes_out_en), 32'h5);
    checkOutput("t4_age0", 32'(dut.u_age_tracker.age_q[0]), 32'd1);
    checkOutput("t4_age2", 32'(dut.u_age_tracker.age_q[2]), 32'd0);
    note_on(70, 1);
    quiesce();
    checkOutput("t4_note1", 32'(notes_out[1]), 32'd70);

    // zero-velocity note-on releases; unmatched note-off is ignored
    do_reset();
    note_on(60, 30); note_on(60, 0);
    quiesce();
    checkOutput("t5_active", 32'(notes_out_en), 32'h0);
    checkOutput("t5_note_held", 32'(notes_out[0]), 32'd60);
    note_off(99);
    quiesce();
    checkOutput("t5_dropped", 32'(note_dropped), 32'd0);
    checkOutput("t5_stolen", 32'(voice_stolen), 32'd0);

    // async reset with all voices busy, then first event goes to voice 0
    note_on(40, 9); note_on(41, 9); note_on(42, 9); note_on(43, 9);
    do_reset();
    note_on(48, 10);
    quiesce();
    checkOutput("t6_active", 32'(notes_out_en), 32'h1);
    checkOutput("t6_note0", 32'(notes_out[0]), 32'd48);

    // randomized traffic over a narrow note range so matches and full cases are frequent
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        applyStimulus(($urandom_range(0, 7) != 0),
                      ($urandom_range(0, 1) == 1) ? NOTE_ON : NOTE_OFF,
                      60 + int'($urandom_range(0, 5)),
                      ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 127)));
      end
    end

    quiesce();
    repeat (2) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
